// File: rtl/secure_log_pkg.sv
// Shared encodings and constants for the secure log readback path.
package secure_log_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 8;

    localparam logic [BYTE_W-1:0] READ_CMD  = 8'h03;
    localparam logic [BYTE_W-1:0] OEB_DRIVE = 8'h00;
    localparam logic [BYTE_W-1:0] OEB_HIZ   = 8'hFF;

    // CMD..SAMPLE are the read-port phases; the top level parks in CMD while a
    // port read is in flight and lets the port report the finer phase.
    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        TURN,
        SAMPLE,
        OUT,
        DONE,
        FAIL
    } state_t;

endpackage

// File: rtl/secure_log_reader_if.sv
// ReRAM bus and readback stream grouped for the log reader.
interface secure_log_reader_if;
    import secure_log_pkg::*;

    logic [BYTE_W-1:0] re_ram_bus_in;
    logic [BYTE_W-1:0] re_ram_bus_out;
    logic [BYTE_W-1:0] re_ram_oeb;
    logic [BYTE_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;

    modport master (
        input  re_ram_bus_in,
        input  data_ready,
        output re_ram_bus_out,
        output re_ram_oeb,
        output data_out,
        output data_valid
    );

    modport slave (
        output re_ram_bus_in,
        output data_ready,
        input  re_ram_bus_out,
        input  re_ram_oeb,
        input  data_out,
        input  data_valid
    );

endinterface

// File: rtl/re_ram_read_port.sv
// Single-address ReRAM read: drive command, drive address, turn the bus, sample.
module re_ram_read_port #(
    parameter logic [secure_log_pkg::BYTE_W-1:0] READ_CMD = secure_log_pkg::READ_CMD
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              go,
    input  logic                              abort,
    input  logic [secure_log_pkg::ADDR_W-1:0] addr,
    output logic [secure_log_pkg::BYTE_W-1:0] bus_out,
    output logic [secure_log_pkg::BYTE_W-1:0] oeb,
    output logic                              sample_c
);
    import secure_log_pkg::*;

    state_t            phase;
    state_t            phase_nxt;
    logic [BYTE_W-1:0] bus_out_nxt;
    logic [BYTE_W-1:0] oeb_nxt;

    // Phase sequencing plus the bus drive that belongs to the upcoming phase.
    always_comb begin
        phase_nxt   = phase;
        bus_out_nxt = '0;
        oeb_nxt     = OEB_HIZ;
        unique case (phase)
            IDLE:    if (go) phase_nxt = CMD;
            CMD:     phase_nxt = ADDR;
            ADDR:    phase_nxt = TURN;
            TURN:    phase_nxt = SAMPLE;
            SAMPLE:  phase_nxt = IDLE;
            default: phase_nxt = IDLE;
        endcase
        if (abort) phase_nxt = IDLE;
        case (phase_nxt)
            CMD: begin
                bus_out_nxt = READ_CMD;
                oeb_nxt     = OEB_DRIVE;
            end
            ADDR: begin
                bus_out_nxt = BYTE_W'(addr);
                oeb_nxt     = OEB_DRIVE;
            end
            default: begin
                bus_out_nxt = '0;
                oeb_nxt     = OEB_HIZ;
            end
        endcase
    end

    // The edge that ends SAMPLE is the capture edge, taken by the top level.
    assign sample_c = (phase == SAMPLE);

    // Phase register with registered bus drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= IDLE;
            bus_out <= '0;
            oeb     <= OEB_HIZ;
        end else begin
            phase   <= phase_nxt;
            bus_out <= bus_out_nxt;
            oeb     <= oeb_nxt;
        end
    end

endmodule

// File: rtl/secure_log_reader.sv
// Reads a run of log records over the ReRAM bus, streams them out and checks
// the XOR checksum against a trailer byte stored after the last record.
module secure_log_reader #(
    parameter int unsigned                       DATA_WIDTH = 8,
    parameter logic [secure_log_pkg::BYTE_W-1:0] READ_CMD   = secure_log_pkg::READ_CMD
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [secure_log_pkg::ADDR_W-1:0] base_addr,
    input  logic [secure_log_pkg::ADDR_W-1:0] length,
    input  logic                              power_fail_detected,
    secure_log_reader_if.master               bus,
    output logic                              ack,
    output logic                              busy,
    output logic                              done,
    output logic                              fail
);
    import secure_log_pkg::*;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_W-1:0]     base;
    logic [ADDR_W-1:0]     count;
    logic [ADDR_W-1:0]     index;
    logic [DATA_WIDTH-1:0] checksum;
    logic [DATA_WIDTH-1:0] stream_data;
    logic                  stream_valid;
    logic [ADDR_W-1:0]     addr;
    logic [BYTE_W-1:0]     port_bus_out;
    logic [BYTE_W-1:0]     port_oeb;
    logic                  sample_c;
    logic                  accept_c;
    logic                  go_c;
    logic                  abort_c;
    logic                  load_c;
    logic                  xfer_c;

    assign addr = ADDR_W'(base + index);

    re_ram_read_port #(
        .READ_CMD (READ_CMD)
    ) u_port (
        .clk      (clk),
        .rst      (rst),
        .go       (go_c),
        .abort    (abort_c),
        .addr     (addr),
        .bus_out  (port_bus_out),
        .oeb      (port_oeb),
        .sample_c (sample_c)
    );

    assign bus.re_ram_bus_out = port_bus_out;
    assign bus.re_ram_oeb     = port_oeb;
    assign bus.data_out       = BYTE_W'(stream_data);
    assign bus.data_valid     = stream_valid;

    // Record/trailer sequencing, start acceptance and power-fail abort.
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        go_c      = 1'b0;
        abort_c   = 1'b0;
        load_c    = 1'b0;
        xfer_c    = 1'b0;
        unique case (state)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    if (power_fail_detected) begin
                        state_nxt = FAIL;
                    end else begin
                        state_nxt = CMD;
                        accept_c  = 1'b1;
                        go_c      = 1'b1;
                    end
                end
            end
            CMD: begin
                if (power_fail_detected) begin
                    state_nxt = FAIL;
                    abort_c   = 1'b1;
                end else if (sample_c) begin
                    if (index < count) begin
                        state_nxt = OUT;
                        load_c    = 1'b1;
                    end else if (DATA_WIDTH'(bus.re_ram_bus_in) == checksum) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FAIL;
                    end
                end
            end
            OUT: begin
                if (power_fail_detected) begin
                    state_nxt = FAIL;
                end else if (bus.data_ready) begin
                    state_nxt = CMD;
                    go_c      = 1'b1;
                    xfer_c    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Latched request, record index, running checksum, stream and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base         <= '0;
            count        <= '0;
            index        <= '0;
            checksum     <= '0;
            stream_data  <= '0;
            stream_valid <= 1'b0;
            ack          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
        end else begin
            ack          <= accept_c;
            busy         <= (state_nxt == CMD) || (state_nxt == OUT);
            done         <= (state_nxt == DONE);
            fail         <= (state_nxt == FAIL);
            stream_valid <= (state_nxt == OUT);
            if (accept_c) begin
                base     <= base_addr;
                count    <= length;
                index    <= '0;
                checksum <= '0;
            end
            if (load_c) begin
                stream_data <= DATA_WIDTH'(bus.re_ram_bus_in);
                checksum    <= checksum ^ DATA_WIDTH'(bus.re_ram_bus_in);
            end
            if (xfer_c) index <= ADDR_W'(index + ADDR_W'(1));
        end
    end

endmodule

// File: tb/tb_secure_log_reader.sv
// Directed bench for secure_log_reader with a small ReRAM responder.
module tb_secure_log_reader;

    localparam logic [7:0] RD_CMD = 8'h03;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] length;
    logic       pf;
    logic       ack;
    logic       busy;
    logic       done;
    logic       fail;

    logic [7:0] mem [256];
    logic [7:0] mem_addr;
    logic       expect_addr;
    logic [7:0] stream [$];
    logic [7:0] addr_log [$];

    int vectors;
    int miscompares;

    secure_log_reader_if bus_if ();

    secure_log_reader #(
        .DATA_WIDTH (8),
        .READ_CMD   (RD_CMD)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .base_addr           (base_addr),
        .length              (length),
        .power_fail_detected (pf),
        .bus                 (bus_if),
        .ack                 (ack),
        .busy                (busy),
        .done                (done),
        .fail                (fail)
    );

    always #5 clk = ~clk;

    assign bus_if.re_ram_bus_in = mem[mem_addr];

    // ReRAM responder: a driven READ_CMD is followed by a driven address.
    always @(negedge clk) begin
        if (rst) begin
            expect_addr <= 1'b0;
            mem_addr    <= 8'h00;
        end else if (bus_if.re_ram_oeb == 8'h00) begin
            if (expect_addr) begin
                mem_addr    <= bus_if.re_ram_bus_out;
                addr_log.push_back(bus_if.re_ram_bus_out);
                expect_addr <= 1'b0;
            end else if (bus_if.re_ram_bus_out == RD_CMD) begin
                expect_addr <= 1'b1;
            end
        end
    end

    // Stream monitor: record every accepted byte.
    always @(posedge clk) begin
        if (!rst && bus_if.data_valid && bus_if.data_ready)
            stream.push_back(bus_if.data_out);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_stream(input string tag, input int n,
                                input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] exp;
        check({tag, " count"}, 32'(stream.size()), 32'(n));
        if (stream.size() == n) begin
            for (int i = 0; i < n; i++) begin
                exp = (i == 0) ? e0 : ((i == 1) ? e1 : e2);
                check($sformatf("%s byte%0d", tag, i), 32'(stream[i]), 32'(exp));
            end
        end
    endtask

    task automatic start_read(input logic [7:0] b, input logic [7:0] l);
        stream.delete();
        addr_log.delete();
        @(negedge clk);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!(done || fail) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) check({tag, " end timeout"}, 32'(done | fail), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus_if.data_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check({tag, " valid timeout"}, 32'(bus_if.data_valid), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " ack"},     32'(ack), 32'd0);
        check({tag, " busy"},    32'(busy), 32'd0);
        check({tag, " done"},    32'(done), 32'd0);
        check({tag, " fail"},    32'(fail), 32'd0);
        check({tag, " valid"},   32'(bus_if.data_valid), 32'd0);
        check({tag, " dout"},    32'(bus_if.data_out), 32'h00);
        check({tag, " bus_out"}, 32'(bus_if.re_ram_bus_out), 32'h00);
        check({tag, " oeb"},     32'(bus_if.re_ram_oeb), 32'hFF);
    endtask

    initial begin
        int n;
        clk         = 1'b0;
        rst         = 1'b1;
        start       = 1'b0;
        pf          = 1'b0;
        base_addr   = 8'h00;
        length      = 8'h00;
        bus_if.data_ready = 1'b0;
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h11;
        mem[8'h11] = 8'h22;
        mem[8'h12] = 8'h33;
        mem[8'h13] = 8'h00;
        mem[8'hFE] = 8'hA1;
        mem[8'hFF] = 8'hB2;
        mem[8'h00] = 8'hC3;
        mem[8'h01] = 8'hD0;
        mem[8'h40] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        // Good readback, first valid five cycles into the transfer.
        bus_if.data_ready = 1'b1;
        start_read(8'h10, 8'd3);
        check("s1 ack", 32'(ack), 32'd1);
        check("s1 busy", 32'(busy), 32'd1);
        check("s1 cmd", 32'(bus_if.re_ram_bus_out), 32'h03);
        check("s1 cmd oeb", 32'(bus_if.re_ram_oeb), 32'h00);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) check("s1 ack pulse", 32'(ack), 32'd0);
            if (k == 1) check("s1 addr", 32'(bus_if.re_ram_bus_out), 32'h10);
            if (k == 2) check("s1 turn oeb", 32'(bus_if.re_ram_oeb), 32'hFF);
            if (k == 3) check("s1 early valid", 32'(bus_if.data_valid), 32'd0);
            if (k == 4) check("s1 first valid", 32'(bus_if.data_valid), 32'd1);
            if (k == 4) check("s1 first data", 32'(bus_if.data_out), 32'h11);
        end
        wait_end("s1");
        check_stream("s1", 3, 8'h11, 8'h22, 8'h33);
        check("s1 done", 32'(done), 32'd1);
        check("s1 fail", 32'(fail), 32'd0);
        check("s1 busy end", 32'(busy), 32'd0);

        // Bad trailer.
        mem[8'h13] = 8'h01;
        start_read(8'h10, 8'd3);
        check("s2 done cleared", 32'(done), 32'd0);
        wait_end("s2");
        check_stream("s2", 3, 8'h11, 8'h22, 8'h33);
        check("s2 fail", 32'(fail), 32'd1);
        check("s2 done", 32'(done), 32'd0);
        mem[8'h13] = 8'h00;

        // Address wrap past 8'hFF.
        start_read(8'hFE, 8'd3);
        wait_end("s3");
        check_stream("s3", 3, 8'hA1, 8'hB2, 8'hC3);
        check("s3 done", 32'(done), 32'd1);
        check("s3 addr count", 32'(addr_log.size()), 32'd4);
        if (addr_log.size() == 4) begin
            check("s3 addr0", 32'(addr_log[0]), 32'hFE);
            check("s3 addr1", 32'(addr_log[1]), 32'hFF);
            check("s3 addr2", 32'(addr_log[2]), 32'h00);
            check("s3 addr3", 32'(addr_log[3]), 32'h01);
        end

        // Four cycles of backpressure on the second byte.
        start_read(8'h10, 8'd3);
        n = 0;
        while (stream.size() < 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("s4 first xfer", 32'(stream.size()), 32'd1);
        bus_if.data_ready = 1'b0;
        wait_valid("s4");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("s4 hold data%0d", i), 32'(bus_if.data_out), 32'h22);
            check($sformatf("s4 hold valid%0d", i), 32'(bus_if.data_valid), 32'd1);
            check($sformatf("s4 quiet oeb%0d", i), 32'(bus_if.re_ram_oeb), 32'hFF);
            check($sformatf("s4 quiet bus%0d", i), 32'(bus_if.re_ram_bus_out), 32'h00);
            @(posedge clk);
            #1;
        end
        bus_if.data_ready = 1'b1;
        wait_end("s4");
        check_stream("s4", 3, 8'h11, 8'h22, 8'h33);
        check("s4 done", 32'(done), 32'd1);

        // Power fail during TURN of record 1, with a start in the same cycle.
        start_read(8'h10, 8'd3);
        n = 0;
        while (stream.size() < 1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("s5 turn oeb", 32'(bus_if.re_ram_oeb), 32'hFF);
        pf    = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        pf    = 1'b0;
        start = 1'b0;
        check("s5 fail", 32'(fail), 32'd1);
        check("s5 busy", 32'(busy), 32'd0);
        check("s5 ack", 32'(ack), 32'd0);
        check("s5 valid", 32'(bus_if.data_valid), 32'd0);
        check("s5 oeb", 32'(bus_if.re_ram_oeb), 32'hFF);
        check("s5 stream", 32'(stream.size()), 32'd1);

        // start together with power fail from FAIL: stays in FAIL, no ack.
        @(negedge clk);
        pf    = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        pf    = 1'b0;
        start = 1'b0;
        check("s6 ack", 32'(ack), 32'd0);
        check("s6 fail", 32'(fail), 32'd1);
        check("s6 busy", 32'(busy), 32'd0);

        // Zero-length log: trailer only.
        start_read(8'h40, 8'd0);
        wait_end("s7");
        check("s7 done", 32'(done), 32'd1);
        check("s7 fail", 32'(fail), 32'd0);
        check("s7 stream", 32'(stream.size()), 32'd0);
        check("s7 addr count", 32'(addr_log.size()), 32'd1);
        if (addr_log.size() == 1) check("s7 addr", 32'(addr_log[0]), 32'h40);

        // Reset while the address is on the bus.
        start_read(8'h40, 8'd0);
        @(posedge clk);
        #1;
        check("s8 addr drive", 32'(bus_if.re_ram_bus_out), 32'h40);
        check("s8 addr oeb", 32'(bus_if.re_ram_oeb), 32'h00);
        rst = 1'b1;
        #1;
        check_idle("s8 async");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("s8 after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/secure_log_reader.md
SECURE_LOG_READER -- requirements
Module: secure_log_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning ReRAM bus and record byte width; it is fixed at 8 and other values are unsupported.
REQ-002 SHALL have parameter READ_CMD, default 8'h03, meaning the command byte driven on the ReRAM bus to start a read.
REQ-003 SHALL have ports: clk, in, 1, the single clock; rst, in, 1, asynchronous active-high reset.
REQ-004 SHALL have ports: start, in, 1, begin readback; base_addr, in, 8, first record address; length, in, 8, number of data records.
REQ-005 SHALL have port power_fail_detected, in, 1, abort request.
REQ-006 SHALL have ports: re_ram_bus_in, in, 8, read data; re_ram_bus_out, out, 8, command/address drive; re_ram_oeb, out, 8, active-low output enable per bit.
REQ-007 SHALL have ports: data_out, out, 8; data_valid, out, 1; data_ready, in, 1; together these form the readback stream.
REQ-008 SHALL have ports: ack, out, 1, start accepted; busy, out, 1; done, out, 1, readback passed; fail, out, 1, checksum mismatch or power fail.

Function
REQ-009 SHALL use these states: IDLE, CMD, ADDR, TURN, SAMPLE, OUT, DONE, FAIL.
REQ-010 SHALL accept start only in IDLE, DONE or FAIL; on acceptance, latch base_addr and length, clear done, fail and checksum, go to CMD, and pulse ack high for exactly the first CMD cycle.
REQ-011 SHALL ignore start while busy.
REQ-012 In CMD, SHALL drive bus_out = READ_CMD with oeb = 8'h00.
REQ-013 In ADDR, SHALL drive bus_out = current address with oeb = 8'h00.
REQ-014 In TURN, SHALL drive bus_out = 8'h00 with oeb = 8'hFF.
REQ-015 In SAMPLE, SHALL drive oeb = 8'hFF and capture re_ram_bus_in on the clock edge that ends SAMPLE.
REQ-016 In all other states, SHALL drive oeb = 8'hFF and bus_out = 8'h00.
REQ-017 Current address SHALL be (base_addr + index) mod 256; wrap from 8'hFF to 8'h00 is legal.
REQ-018 For index < length, the captured byte SHALL go to OUT with data_out = byte and data_valid = 1, and checksum ^= byte.
REQ-019 data_valid and data_out SHALL hold stable until a cycle where data_ready = 1; that cycle is the transfer, after which index increments and the state returns to CMD.
REQ-020 First data_valid SHALL assert 5 cycles after the start-accepting edge, given no stall; each record costs 5 cycles plus backpressure.
REQ-021 For index == length, the captured byte SHALL be the trailer and SHALL NOT be streamed; if it equals the checksum, go to DONE, otherwise go to FAIL.
REQ-022 length = 0 SHALL read only the trailer at base_addr, compared against checksum 8'h00.
REQ-023 done SHALL be high only in DONE and fail only in FAIL; both hold until the next accepted start or reset.
REQ-024 busy SHALL be high in CMD, ADDR, TURN, SAMPLE and OUT.
REQ-025 power_fail_detected high while busy SHALL force FAIL on the next edge, deassert data_valid and set oeb = 8'hFF; a record pending in OUT is dropped.
REQ-026 start and power_fail_detected high together in IDLE, DONE or FAIL SHALL go to FAIL, with no ack pulse.
REQ-027 data_ready SHALL be ignored when data_valid = 0.

Reset
REQ-028 rst high SHALL asynchronously force IDLE with ack = 0, busy = 0, done = 0, fail = 0, data_valid = 0, data_out = 8'h00, bus_out = 8'h00, oeb = 8'hFF, and clear checksum, index and latched inputs.
REQ-029 Reset mid-transfer SHALL abandon the transfer with no further bus drive.

Structure
REQ-030 Package secure_log_pkg SHALL hold the state encoding, READ_CMD, OEB_DRIVE = 8'h00 and OEB_HIZ = 8'hFF.
REQ-031 Sub-module re_ram_read_port SHALL sequence CMD/ADDR/TURN/SAMPLE for one address; the top level SHALL own indexing, checksum, the stream and status.

Verification
REQ-032 Scenario: base 8'h10, length 3, memory 8'h11/8'h22/8'h33, trailer 8'h00 at 8'h13, data_ready = 1 -> stream 11, 22, 33 with the first valid 5 cycles after start, then done = 1.
REQ-033 Scenario: same setup, trailer 8'h01 -> three bytes streamed, fail = 1, done = 0.
REQ-034 Scenario: base 8'hFE, length 3 -> addresses FE, FF, 00, then trailer read at 01.
REQ-035 Scenario: data_ready = 0 for 4 cycles on the second byte -> data_out holds 8'h22, data_valid stays high, and no bus activity occurs.
REQ-036 Scenario: power_fail_detected pulse during TURN of record 1 -> FAIL next edge, oeb = 8'hFF, data_valid = 0; start in the same cycle is ignored.
REQ-037 Scenario: length 0 with trailer 8'h00 -> done with no stream; rst asserted mid-ADDR -> immediate IDLE outputs per REQ-028.
